// File: rtl/snoop_pkg.sv
// Shared snoop-path types: the ACE CR response fields returned by the snoop controller.
package snoop_pkg;

   typedef struct packed {
      logic was_unique;
      logic is_shared;
      logic pass_dirty;
      logic error;
      logic data_transfer;
   } crresp_t;

endpackage

// File: rtl/snoop_resp_buffer.sv
// Buffers complete snoop results (CR response + cache line) and replays them in order
// on the ACE CR channel and, as DATA_WIDTH beats, on the CD channel.
module snoop_resp_buffer
   import snoop_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int LINE_WIDTH = 128,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  crresp_t               req_resp_i,
   input  logic [LINE_WIDTH-1:0] req_data_i,
   output logic                  cr_valid_o,
   input  logic                  cr_ready_i,
   output crresp_t               cr_resp_o,
   output logic                  cd_valid_o,
   input  logic                  cd_ready_i,
   output logic [DATA_WIDTH-1:0] cd_data_o,
   output logic                  cd_last_o,
   output logic                  busy_o
);

   localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
   localparam int PW    = $clog2(DEPTH);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;
   typedef logic [BW-1:0] beat_t;

   typedef struct packed {
      crresp_t               resp;
      logic [LINE_WIDTH-1:0] line;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [DEPTH-1:0] cr_pend_q, cd_pend_q;
   ptr_t             wr_ptr_q, cr_ptr_q, cd_ptr_q, rt_ptr_q;
   cnt_t             count_q;
   cnt_t             cd_cnt_q;   // entries the CD side has not yet walked past
   beat_t            beat_q;

   logic enq, cr_hs, cd_hs, cd_last_hs, cd_skip, cd_adv, retire;
   logic cr_done_rt, cd_done_rt, cd_passed_rt;

   assign req_ready_o = (count_q != cnt_t'(DEPTH));
   assign busy_o      = (count_q != '0);
   assign enq         = req_valid_i & req_ready_o;

   assign cr_valid_o = cr_pend_q[cr_ptr_q];
   assign cr_resp_o  = cr_valid_o ? mem_q[cr_ptr_q].resp : '0;
   assign cr_hs      = cr_valid_o & cr_ready_i;

   // A no-data entry is stepped over in one bubble cycle without raising cd_valid_o.
   assign cd_skip    = (cd_cnt_q != '0) & ~mem_q[cd_ptr_q].resp.data_transfer;
   assign cd_valid_o = (cd_cnt_q != '0) & mem_q[cd_ptr_q].resp.data_transfer & cd_pend_q[cd_ptr_q];
   assign cd_last_o  = cd_valid_o & (beat_q == beat_t'(BEATS - 1));
   assign cd_data_o  = cd_valid_o ? mem_q[cd_ptr_q].line[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
   assign cd_hs      = cd_valid_o & cd_ready_i;
   assign cd_last_hs = cd_hs & cd_last_o;
   assign cd_adv     = cd_skip | cd_last_hs;

   // Retire looks at this cycle's handshakes so a drained entry frees its slot one cycle earlier.
   assign cr_done_rt   = ~cr_pend_q[rt_ptr_q] | (cr_hs & (cr_ptr_q == rt_ptr_q));
   assign cd_done_rt   = ~cd_pend_q[rt_ptr_q] | (cd_last_hs & (cd_ptr_q == rt_ptr_q));
   assign cd_passed_rt = (cd_cnt_q != count_q) | (cd_adv & (cd_ptr_q == rt_ptr_q));
   assign retire       = busy_o & cr_done_rt & cd_done_rt & cd_passed_rt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         cr_ptr_q  <= '0;
         cd_ptr_q  <= '0;
         rt_ptr_q  <= '0;
         count_q   <= '0;
         cd_cnt_q  <= '0;
         beat_q    <= '0;
         cr_pend_q <= '0;
         cd_pend_q <= '0;
      end else begin
         if (enq) begin
            wr_ptr_q            <= wr_ptr_q + ptr_t'(1);
            cr_pend_q[wr_ptr_q] <= 1'b1;
            cd_pend_q[wr_ptr_q] <= req_resp_i.data_transfer;
         end
         if (cr_hs) begin
            cr_pend_q[cr_ptr_q] <= 1'b0;
            cr_ptr_q            <= cr_ptr_q + ptr_t'(1);
         end
         if (cd_hs) begin
            beat_q <= cd_last_o ? '0 : beat_q + beat_t'(1);
         end
         if (cd_last_hs) begin
            cd_pend_q[cd_ptr_q] <= 1'b0;
         end
         if (cd_adv) begin
            cd_ptr_q <= cd_ptr_q + ptr_t'(1);
         end
         if (retire) begin
            rt_ptr_q <= rt_ptr_q + ptr_t'(1);
         end
         count_q  <= count_q + cnt_t'(enq) - cnt_t'(retire);
         cd_cnt_q <= cd_cnt_q + cnt_t'(enq) - cnt_t'(cd_adv);
      end
   end

   // NOTE: payload storage is deliberately not reset; the pend bits qualify it and outputs are gated.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wr_ptr_q].resp <= req_resp_i;
         if (req_resp_i.data_transfer) begin
            mem_q[wr_ptr_q].line <= req_data_i;
         end
      end
   end

endmodule
